// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch / program-counter stage.
package fetch_pkg;

  localparam int unsigned PC_W_DEFAULT  = 10;
  localparam int unsigned CNT_W_DEFAULT = 16;
  localparam int unsigned BR_FIELD_W    = 4;
  localparam int unsigned LUT_DEPTH     = 16;
  localparam int unsigned LUT_ENTRY_W   = PC_W_DEFAULT;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun,
    StHalt
  } fetch_state_t;

  // Absolute branch targets; a literal wider than LUT_ENTRY_W fails width lint.
  localparam logic [LUT_ENTRY_W-1:0] BRANCH_LUT [LUT_DEPTH] = '{
    10'd0,   10'd16,  10'd32,  10'd64,
    10'd128, 10'd300, 10'd512, 10'd1023,
    10'd7,   10'd48,  10'd200, 10'd400,
    10'd600, 10'd800, 10'd900, 10'd1000
  };

endpackage

// File: rtl/fetch_pc_unit_branch_lut.sv
// Combinational branch-target lookup: 4-bit branch field to absolute PC.
module branch_lut
  import fetch_pkg::*;
#(
  parameter int unsigned PC_W = PC_W_DEFAULT
) (
  input  logic [BR_FIELD_W-1:0] idx_i,
  output logic [PC_W-1:0]       target_o
);

  assign target_o = PC_W'(BRANCH_LUT[idx_i]);

endmodule

// File: rtl/fetch_pc_unit.sv
// Program counter, Start/Ack run handshake and run-cycle counter.
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter int unsigned PC_W  = PC_W_DEFAULT,
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic                  jump_en,
  input  logic                  immOrLUT,
  input  logic [BR_FIELD_W-1:0] branch_field,
  input  logic                  stall,
  input  logic                  done,
  output logic [PC_W-1:0]       prog_ctr,
  output logic                  Ack,
  output logic                  running,
  output logic [CNT_W-1:0]      cycle_count
);

  fetch_state_t     state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             ack_q, ack_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PC_W-1:0]  lut_target;
  logic [PC_W-1:0]  rel_off;

  branch_lut #(
    .PC_W (PC_W)
  ) u_branch_lut (
    .idx_i    (branch_field),
    .target_o (lut_target)
  );

  assign rel_off = PC_W'($signed(branch_field));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ack_d   = ack_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        pc_d  = '0;
        ack_d = 1'b0;
        if (Start) state_d = StLoad;
      end
      StLoad: begin
        pc_d  = '0;
        ack_d = 1'b0;
        cnt_d = '0;
        if (!Start) state_d = StRun;
      end
      StRun: begin
        // Counts stalled and done cycles too; saturates rather than wraps.
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
        if (Start) begin
          state_d = StLoad;
          pc_d    = '0;
          cnt_d   = '0;
        end else if (done) begin
          state_d = StHalt;
          ack_d   = 1'b1;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (jump_en && immOrLUT) begin
          pc_d = lut_target;
        end else if (jump_en) begin
          pc_d = pc_q + rel_off;
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end
      StHalt: begin
        if (Start) begin
          state_d = StLoad;
          pc_d    = '0;
          ack_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= StIdle;
      pc_q    <= '0;
      ack_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ack_q   <= ack_d;
      cnt_q   <= cnt_d;
    end
  end

  assign prog_ctr    = pc_q;
  assign Ack         = ack_q;
  assign running     = (state_q == StRun);
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit against a behavioural fetch model.
module tb_fetch_pc_unit;

  localparam int PcW  = 10;
  localparam int CntW = 4;
  localparam int PcMod  = 1 << PcW;
  localparam int CntMax = (1 << CntW) - 1;

  logic            Clk = 1'b0;
  logic            Reset = 1'b1;
  logic            Start = 1'b0;
  logic            jump_en = 1'b0;
  logic            immOrLUT = 1'b0;
  logic [3:0]      branch_field = 4'd0;
  logic            stall = 1'b0;
  logic            done = 1'b0;
  logic [PcW-1:0]  prog_ctr;
  logic            Ack;
  logic            running;
  logic [CntW-1:0] cycle_count;

  fetch_pc_unit #(
    .PC_W  (PcW),
    .CNT_W (CntW)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Start        (Start),
    .jump_en      (jump_en),
    .immOrLUT     (immOrLUT),
    .branch_field (branch_field),
    .stall        (stall),
    .done         (done),
    .prog_ctr     (prog_ctr),
    .Ack          (Ack),
    .running      (running),
    .cycle_count  (cycle_count)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string name;
    int    pc;
    int    ack;
    int    run;
    int    cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Expected branch-table contents.
  int lut_ref [16] = '{0, 16, 32, 64, 128, 300, 512, 1023, 7, 48, 200, 400, 600, 800, 900, 1000};

  // Model: mode is one of "idle", "load", "run", "halt".
  string m_mode = "idle";
  int    m_pc = 0;
  int    m_ack = 0;
  int    m_cnt = 0;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", nm, act, req);
    end
  endtask

  task automatic model_step(input bit rst, input bit st, input bit j, input bit imm,
                            input int bf, input bit stl, input bit dn);
    int off;
    if (rst) begin
      m_mode = "idle"; m_pc = 0; m_ack = 0; m_cnt = 0;
    end else if (m_mode == "idle") begin
      if (st) m_mode = "load";
    end else if (m_mode == "load") begin
      m_pc = 0; m_ack = 0; m_cnt = 0;
      if (!st) m_mode = "run";
    end else if (m_mode == "run") begin
      m_cnt = (m_cnt < CntMax) ? m_cnt + 1 : CntMax;
      if (st) begin
        m_mode = "load"; m_pc = 0; m_cnt = 0;
      end else if (dn) begin
        m_mode = "halt"; m_ack = 1;
      end else if (stl) begin
        m_pc = m_pc;
      end else if (j && imm) begin
        m_pc = lut_ref[bf];
      end else if (j) begin
        off  = (bf >= 8) ? bf - 16 : bf;
        m_pc = (m_pc + off + PcMod) % PcMod;
      end else begin
        m_pc = (m_pc + 1) % PcMod;
      end
    end else begin
      if (st) begin
        m_mode = "load"; m_pc = 0; m_ack = 0; m_cnt = 0;
      end
    end
  endtask

  // One clock cycle of stimulus; pushes the outputs expected after the edge.
  task automatic cyc(input string nm, input bit rst, input bit st, input bit j, input bit imm,
                     input int bf, input bit stl, input bit dn);
    exp_t e;
    @(negedge Clk);
    Reset = rst; Start = st; jump_en = j; immOrLUT = imm;
    branch_field = 4'(bf); stall = stl; done = dn;
    model_step(rst, st, j, imm, bf, stl, dn);
    e.name = nm;
    e.pc   = m_pc;
    e.ack  = m_ack;
    e.run  = (m_mode == "run") ? 1 : 0;
    e.cnt  = m_cnt;
    exp_q.push_back(e);
  endtask

  // Monitor: outputs are presented every cycle, compared just after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({e.name, ".prog_ctr"},    int'(prog_ctr),    e.pc);
        chk({e.name, ".Ack"},         int'(Ack),         e.ack);
        chk({e.name, ".running"},     int'(running),     e.run);
        chk({e.name, ".cycle_count"}, int'(cycle_count), e.cnt);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running required finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int guard;
    cyc("reset", 1, 0, 0, 0, 0, 0, 0);
    cyc("reset", 1, 0, 0, 0, 0, 0, 0);
    cyc("idle", 0, 0, 1, 0, 0, 1, 1);

    // Start handshake then sequential fetch up to PC 37, then reset mid-run.
    for (int i = 0; i < 3; i++) cyc("start_hold", 0, 1, 0, 0, 0, 0, 0);
    guard = 0;
    while (m_pc != 37 && guard < 200) begin
      cyc("run_seq", 0, 0, 0, 0, 0, 0, 0);
      guard++;
    end
    chk("reach_pc37", m_pc, 37);
    cyc("reset_mid_run", 1, 0, 0, 0, 0, 0, 0);

    // Relative branches: 20 -> 17, 1 -> 1022 (wrap), self-loop at offset 0.
    cyc("start", 0, 1, 0, 0, 0, 0, 0);
    cyc("load", 0, 0, 0, 0, 0, 0, 0);
    while (m_pc != 20 && guard < 400) begin
      cyc("run_seq", 0, 0, 0, 0, 0, 0, 0);
      guard++;
    end
    cyc("rel_minus3", 0, 0, 1, 0, 13, 0, 0);
    cyc("rel_selfloop", 0, 0, 1, 0, 0, 0, 0);
    cyc("abort", 0, 1, 0, 0, 0, 0, 0);
    cyc("load", 0, 0, 0, 0, 0, 0, 0);
    cyc("run_pc0", 0, 0, 0, 0, 0, 0, 0);
    cyc("rel_wrap", 0, 0, 1, 0, 13, 0, 0);
    cyc("rel_plus7", 0, 0, 1, 0, 7, 0, 0);

    // LUT branch and stall overriding it.
    cyc("lut5", 0, 0, 1, 1, 5, 0, 0);
    cyc("lut5_stall", 0, 0, 1, 1, 5, 1, 0);

    // Stall/done priority around PC 50.
    cyc("abort", 0, 1, 0, 0, 0, 0, 0);
    cyc("load", 0, 0, 0, 0, 0, 0, 0);
    cyc("lut9", 0, 0, 1, 1, 9, 0, 0);
    cyc("run49", 0, 0, 0, 0, 0, 0, 0);
    cyc("run50", 0, 0, 0, 0, 0, 0, 0);
    cyc("stall1", 0, 0, 0, 0, 0, 1, 0);
    cyc("stall2", 0, 0, 0, 0, 0, 1, 0);
    cyc("done_stall", 0, 0, 1, 0, 3, 1, 1);
    cyc("halt_jump", 0, 0, 1, 1, 7, 0, 0);
    cyc("halt_hold", 0, 0, 1, 0, 2, 1, 1);

    // Restart from HALT and counter saturation.
    cyc("restart", 0, 1, 0, 0, 0, 0, 0);
    cyc("load", 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) cyc("saturate", 0, 0, 0, 0, 0, 0, 0);
    chk("sat_model", m_cnt, CntMax);

    // Randomized operation.
    for (int i = 0; i < 600; i++) begin
      cyc("random", ($urandom_range(63) == 0), ($urandom_range(15) == 0),
          ($urandom_range(2) == 0), 1'($urandom), int'($urandom_range(15)),
          ($urandom_range(3) == 0), ($urandom_range(19) == 0));
    end

    @(posedge Clk);
    #2;
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
